if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, runs one outstanding
//                fetch at a time on an SRAM-like bus, buffers the returned
//                word and presents it to the IF/ID register. Handles branch
//                redirects (with one delay slot) and exception flushes.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          EXC_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       stall,
    input  logic             exception,
    input  logic [31:0]      exception_pc,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    output logic             inst_req,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [31:0]      inst_rdata,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic [EXC_W-1:0] if_exception_type,
    output logic             inst_stall_req
);

    localparam logic [EXC_W-1:0] c_exc_adel = {{(EXC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,   // request on the bus
        S_WAIT  = 2'd1,   // address accepted, waiting for data
        S_DONE  = 2'd2,   // instruction buffered and presented
        S_FAULT = 2'd3    // misaligned PC presented as AdEL
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_req_addr, w_req_addr_nx;
    logic [31:0] r_ibuf, w_ibuf_nx;
    logic [31:0] r_pend_target, w_pend_target_nx;
    logic        r_branch_pend, w_branch_pend_nx;
    logic        r_kill, w_kill_nx;

    logic        w_presenting;
    logic        w_busy;
    logic        w_advance;
    logic        w_complete;
    logic [31:0] w_next_pc;
    logic [31:0] w_entry_pc;
    logic        w_entry_fault;

    assign w_presenting = (r_state == S_DONE) || (r_state == S_FAULT);
    assign w_busy       = !w_presenting;
    assign w_advance    = w_presenting && (stall == 4'b0000) && !exception;
    // Current transaction finishes this cycle (data may arrive with the address)
    assign w_complete   = ((r_state == S_WAIT) && inst_data_ok) ||
                          ((r_state == S_REQ) && inst_addr_ok && inst_data_ok);

    // A branch seen this cycle beats an earlier latched one
    assign w_next_pc = branch_flag   ? branch_target :
                       r_branch_pend ? r_pend_target :
                                       r_pc + 32'd4;

    // Address used when (re)entering REQ/FAULT: after a killed fetch the PC
    // already holds the redirect target, otherwise it is the sequential next.
    assign w_entry_pc    = exception ? exception_pc : (w_busy ? r_pc : w_next_pc);
    assign w_entry_fault = (w_entry_pc[1:0] != 2'b00);

    // Next-state, PC and branch-latch computation
    always_comb begin
        w_state_nx       = r_state;
        w_pc_nx          = r_pc;
        w_req_addr_nx    = r_req_addr;
        w_ibuf_nx        = r_ibuf;
        w_kill_nx        = r_kill;
        w_branch_pend_nx = r_branch_pend;
        w_pend_target_nx = r_pend_target;

        if (exception) begin
            w_pc_nx          = exception_pc;
            w_branch_pend_nx = 1'b0;
        end else if (w_advance) begin
            w_pc_nx          = w_next_pc;
            w_branch_pend_nx = 1'b0;
        end else if (branch_flag) begin
            w_branch_pend_nx = 1'b1;
            w_pend_target_nx = branch_target;
        end

        case (r_state)
            S_REQ, S_WAIT: begin
                if (w_complete) begin
                    w_kill_nx = 1'b0;
                    if (r_kill || exception) begin
                        // Flushed transaction: drop the data, refetch at new PC
                        w_state_nx    = w_entry_fault ? S_FAULT : S_REQ;
                        w_req_addr_nx = w_entry_pc;
                    end else begin
                        w_ibuf_nx  = inst_rdata;
                        w_state_nx = S_DONE;
                    end
                end else begin
                    if ((r_state == S_REQ) && inst_addr_ok) begin
                        w_state_nx = S_WAIT;
                    end
                    if (exception) begin
                        w_kill_nx = 1'b1;
                    end
                end
            end
            default: begin
                if (exception || w_advance) begin
                    w_state_nx    = w_entry_fault ? S_FAULT : S_REQ;
                    w_req_addr_nx = w_entry_pc;
                end
            end
        endcase
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_ibuf        <= 32'd0;
            r_pend_target <= 32'd0;
            r_branch_pend <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_req_addr    <= w_req_addr_nx;
            r_ibuf        <= w_ibuf_nx;
            r_pend_target <= w_pend_target_nx;
            r_branch_pend <= w_branch_pend_nx;
            r_kill        <= w_kill_nx;
        end
    end

    // Bus and pipeline-facing outputs
    always_comb begin
        inst_req          = (r_state == S_REQ) && !rst;
        inst_addr         = r_req_addr;
        if_pc             = r_pc;
        if_instr          = (r_state == S_DONE) ? r_ibuf : 32'd0;
        if_exception_type = (r_state == S_FAULT) ? c_exc_adel : {EXC_W{1'b0}};
        inst_stall_req    = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit: directed scenarios
//                plus a randomized run against a program-order PC model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_rst_pc = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall;
    logic        exception;
    logic [31:0] exception_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [5:0]  if_exception_type;
    logic        inst_stall_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(c_rst_pc), .EXC_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .exception(exception),
        .exception_pc(exception_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .if_pc(if_pc), .if_instr(if_instr),
        .if_exception_type(if_exception_type), .inst_stall_req(inst_stall_req)
    );

    // Memory contents as a pure function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = 32'hBFC0_0000 | (32'($urandom_range(0, 255)) << 4);
        if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answer the current request after a_wait refused cycles and d_wait data cycles
    task automatic serve(input int a_wait, input int d_wait);
        logic [31:0] a;
        a = inst_addr;
        inst_addr_ok = 1'b0;
        repeat (a_wait) tick();
        inst_addr_ok = 1'b1;
        inst_data_ok = (d_wait == 0);
        inst_rdata   = mem(a);
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (d_wait > 0) begin
            repeat (d_wait - 1) tick();
            inst_data_ok = 1'b1;
            tick();
            inst_data_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 4'b0000; exception = 1'b0; exception_pc = 32'd0;
        branch_flag = 1'b0; branch_target = 32'd0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (inst_req !== 1'b0 || inst_stall_req !== 1'b1 || if_pc !== c_rst_pc ||
            if_instr !== 32'd0 || if_exception_type !== 6'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b stall_req=%b pc=%h instr=%h exc=%h, want 0 1 %h 0 0",
                     inst_req, inst_stall_req, if_pc, if_instr, if_exception_type, c_rst_pc);
        end
        rst = 1'b0;
        #1;
        total++;
        if (inst_req !== 1'b1 || inst_addr !== c_rst_pc) begin
            bad++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 %h", inst_req, inst_addr, c_rst_pc);
        end
    endtask

    task automatic test_basic_fetch();
        inst_addr_ok = 1'b1;
        tick();
        total++;
        if (inst_req !== 1'b0 || inst_stall_req !== 1'b1) begin
            bad++;
            $display("FAIL wait_state: req=%b stall_req=%b want 0 1", inst_req, inst_stall_req);
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        stall = 4'b0100;
        tick();
        inst_data_ok = 1'b0;
        total++;
        if (if_pc !== 32'hBFC0_0000 || if_instr !== 32'h2408_0001 || inst_stall_req !== 1'b0 ||
            if_exception_type !== 6'd0) begin
            bad++;
            $display("FAIL first_instr: pc=%h instr=%h stall_req=%b exc=%h want bfc00000 24080001 0 00",
                     if_pc, if_instr, inst_stall_req, if_exception_type);
        end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (if_pc !== 32'hBFC0_0000 || if_instr !== 32'h2408_0001 || inst_req !== 1'b0 ||
                inst_stall_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h req=%b stall_req=%b",
                         i, if_pc, if_instr, inst_req, inst_stall_req);
            end
        end
        stall = 4'b0000;
        tick();
        total++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004 || inst_stall_req !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: req=%b addr=%h stall_req=%b want 1 bfc00004 1",
                     inst_req, inst_addr, inst_stall_req);
        end
    endtask

    task automatic test_branch_delay_slot();
        stall = 4'b0100;
        serve(0, 1);
        total++;
        if (if_pc !== 32'hBFC0_0004 || if_instr !== mem(32'hBFC0_0004)) begin
            bad++;
            $display("FAIL seq_instr: pc=%h instr=%h want bfc00004 %h", if_pc, if_instr, mem(32'hBFC0_0004));
        end
        stall = 4'b0000;
        tick();
        branch_flag = 1'b1; branch_target = 32'hBFC0_0100;
        tick();
        branch_flag = 1'b0;
        serve(1, 2);
        total++;
        if (if_pc !== 32'hBFC0_0008 || if_instr !== mem(32'hBFC0_0008) || inst_stall_req !== 1'b0) begin
            bad++;
            $display("FAIL delay_slot: pc=%h instr=%h stall_req=%b want bfc00008 %h 0",
                     if_pc, if_instr, inst_stall_req, mem(32'hBFC0_0008));
        end
        tick();
        total++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0100) begin
            bad++;
            $display("FAIL branch_target: req=%b addr=%h want 1 bfc00100", inst_req, inst_addr);
        end
    endtask

    task automatic test_exception_wait();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        exception = 1'b1; exception_pc = 32'hBFC0_0380;
        tick();
        exception = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = mem(32'hBFC0_0100);
        tick();
        inst_data_ok = 1'b0;
        total++;
        if (if_instr !== 32'd0 || inst_stall_req !== 1'b1 || inst_req !== 1'b1 ||
            inst_addr !== 32'hBFC0_0380 || if_pc !== 32'hBFC0_0380) begin
            bad++;
            $display("FAIL exc_discard: instr=%h stall_req=%b req=%b addr=%h pc=%h want 0 1 1 bfc00380",
                     if_instr, inst_stall_req, inst_req, inst_addr, if_pc);
        end
    endtask

    task automatic test_misaligned();
        stall = 4'b0100;
        serve(0, 0);
        total++;
        if (if_pc !== 32'hBFC0_0380 || if_instr !== mem(32'hBFC0_0380) || inst_stall_req !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle_data: pc=%h instr=%h stall_req=%b", if_pc, if_instr, inst_stall_req);
        end
        stall = 4'b0000; branch_flag = 1'b1; branch_target = 32'hBFC0_0102;
        tick();
        branch_flag = 1'b0; stall = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (inst_req !== 1'b0 || if_pc !== 32'hBFC0_0102 || if_instr !== 32'd0 ||
                if_exception_type !== 6'h01 || inst_stall_req !== 1'b0) begin
                bad++;
                $display("FAIL adel_fault[%0d]: req=%b pc=%h instr=%h exc=%h stall_req=%b want 0 bfc00102 0 01 0",
                         i, inst_req, if_pc, if_instr, if_exception_type, inst_stall_req);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if (if_pc !== c_rst_pc || inst_stall_req !== 1'b1 || inst_req !== 1'b0 ||
            if_exception_type !== 6'd0) begin
            bad++;
            $display("FAIL async_reset: pc=%h stall_req=%b req=%b exc=%h want %h 1 0 00",
                     if_pc, inst_stall_req, inst_req, if_exception_type, c_rst_pc);
        end
        stall = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_addr_withheld();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin exception = 1'b1; exception_pc = 32'hBFC0_0200; end
            tick();
            exception = 1'b0;
            total++;
            if (inst_req !== 1'b1 || inst_addr !== c_rst_pc) begin
                bad++;
                $display("FAIL addr_stable[%0d]: req=%b addr=%h want 1 %h", i, inst_req, inst_addr, c_rst_pc);
            end
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = mem(c_rst_pc);
        tick();
        inst_data_ok = 1'b0;
        total++;
        if (inst_stall_req !== 1'b1 || if_instr !== 32'd0 || inst_req !== 1'b1 ||
            inst_addr !== 32'hBFC0_0200) begin
            bad++;
            $display("FAIL withheld_kill: stall_req=%b instr=%h req=%b addr=%h want 1 0 1 bfc00200",
                     inst_stall_req, if_instr, inst_req, inst_addr);
        end
    endtask

    // Random traffic checked against a program-order model of the PC stream
    task automatic test_random(input int n);
        logic [31:0] exp_pc, pend_tgt, seen_addr;
        bit pend, seen, outstanding, stale, active, complete, adv, exp_present, exp_new;
        exp_pc = 32'hBFC0_0200; pend_tgt = 32'd0; seen_addr = 32'd0;
        pend = 0; seen = 0; outstanding = 0; stale = 0;
        for (int c = 0; c < n; c++) begin
            total++;
            if (inst_stall_req === 1'b0) begin
                if (exp_pc[1:0] != 2'b00) begin
                    if (if_pc !== exp_pc || if_instr !== 32'd0 || if_exception_type !== 6'h01 || inst_req !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd_fault c=%0d: pc=%h instr=%h exc=%h req=%b want pc %h",
                                 c, if_pc, if_instr, if_exception_type, inst_req, exp_pc);
                    end
                end else if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_exception_type !== 6'd0 || inst_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_present c=%0d: pc=%h instr=%h exc=%h req=%b want %h %h",
                             c, if_pc, if_instr, if_exception_type, inst_req, exp_pc, mem(exp_pc));
                end
            end else if (if_instr !== 32'd0 || if_exception_type !== 6'd0) begin
                bad++;
                $display("FAIL rnd_idle c=%0d: instr=%h exc=%h want 0 0", c, if_instr, if_exception_type);
            end
            if (inst_req === 1'b1) begin
                total++;
                if (!seen && inst_addr !== exp_pc) begin
                    bad++;
                    $display("FAIL rnd_req_addr c=%0d: addr=%h want %h", c, inst_addr, exp_pc);
                end else if (seen && inst_addr !== seen_addr) begin
                    bad++;
                    $display("FAIL rnd_addr_stable c=%0d: addr=%h want %h", c, inst_addr, seen_addr);
                end
                if (!seen) begin seen = 1; seen_addr = inst_addr; end
            end

            active        = (inst_req === 1'b1) || outstanding;
            inst_addr_ok  = (inst_req === 1'b1) && ($urandom_range(0, 1) == 1);
            inst_data_ok  = outstanding ? ($urandom_range(0, 99) < 40)
                                        : (inst_addr_ok && ($urandom_range(0, 99) < 25));
            inst_rdata    = inst_data_ok ? mem(outstanding ? seen_addr : inst_addr) : $urandom;
            stall         = ($urandom_range(0, 99) < 60) ? 4'b0000 : 4'($urandom_range(1, 15));
            exception     = ($urandom_range(0, 99) < 6);
            exception_pc  = rnd_tgt();
            branch_flag   = ($urandom_range(0, 99) < 15);
            branch_target = rnd_tgt();

            adv      = (inst_stall_req === 1'b0) && (stall == 4'b0000) && !exception;
            complete = (outstanding && inst_data_ok) || ((inst_req === 1'b1) && inst_addr_ok && inst_data_ok);
            if (active && exception) stale = 1;
            exp_present = complete && !stale;
            exp_new     = adv || (exception && !active) || (complete && stale);
            if (exception) begin
                exp_pc = exception_pc; pend = 0;
            end else if (adv) begin
                exp_pc = branch_flag ? branch_target : (pend ? pend_tgt : exp_pc + 32'd4);
                pend = 0;
            end else if (branch_flag) begin
                pend = 1; pend_tgt = branch_target;
            end
            if ((inst_req === 1'b1) && inst_addr_ok && !inst_data_ok) outstanding = 1;
            if (complete) begin outstanding = 0; seen = 0; stale = 0; end

            tick();
            if (exp_present) begin
                total++;
                if (inst_stall_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_latency c=%0d: stall_req=%b want 0", c, inst_stall_req);
                end
            end
            if (exp_new) begin
                total++;
                if ((exp_pc[1:0] == 2'b00) ? (inst_req !== 1'b1 || inst_stall_req !== 1'b1)
                                           : (inst_req !== 1'b0 || inst_stall_req !== 1'b0)) begin
                    bad++;
                    $display("FAIL rnd_redirect c=%0d: req=%b stall_req=%b for pc %h",
                             c, inst_req, inst_stall_req, exp_pc);
                end
            end
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; exception = 1'b0; branch_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_branch_delay_slot();
        test_exception_wait();
        test_misaligned();
        test_async_reset();
        test_addr_withheld();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
